// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment display readers: glyph patterns, scan FSM states, decoder.
// Latency: n/a (constants, types and a pure combinational function).
// Backpressure: n/a.
package seg7_pkg;

    // Segment bit positions on the active-low bus (bit0 = a ... bit6 = g).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, written gfedcba.
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } scan_state_t;

    // Decoded digit, packs as {err, blank, val[3:0]}.
    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] val;
    } hex_dec_t;

    // Unknown patterns decode to val=0 with err set; blank decodes to val=0 with blank set.
    function automatic hex_dec_t seg7_to_hex(input logic [6:0] seg);
        hex_dec_t d;
        d = '0;
        case (seg)
            GLYPH_0:   d.val = 4'h0;
            GLYPH_1:   d.val = 4'h1;
            GLYPH_2:   d.val = 4'h2;
            GLYPH_3:   d.val = 4'h3;
            GLYPH_4:   d.val = 4'h4;
            GLYPH_5:   d.val = 4'h5;
            GLYPH_6:   d.val = 4'h6;
            GLYPH_7:   d.val = 4'h7;
            GLYPH_8:   d.val = 4'h8;
            GLYPH_9:   d.val = 4'h9;
            GLYPH_A:   d.val = 4'hA;
            GLYPH_B:   d.val = 4'hB;
            GLYPH_C:   d.val = 4'hC;
            GLYPH_D:   d.val = 4'hD;
            GLYPH_E:   d.val = 4'hE;
            GLYPH_F:   d.val = 4'hF;
            SEG_BLANK: d.blank = 1'b1;
            default:   d.err = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational active-low 7-segment glyph to hex decoder with blank/error flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] val,
    output logic       blank,
    output logic       err
);

    hex_dec_t dec;

    assign dec   = seg7_to_hex(seg);
    assign val   = dec.val;
    assign blank = dec.blank;
    assign err   = dec.err;

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a scanned active-low 7-segment bus and emits complete frames.
// Latency: 2-cycle input sync, STABLE_CYC samples per digit; frame registers load on the last digit's capture edge.
// Backpressure: valid/ready; a frame completing while the held frame is unconsumed is dropped and sets sticky overflow.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_n,
    input  logic [NDIG-1:0]     an_n,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [4*NDIG-1:0]   frame_val,
    output logic [NDIG-1:0]     frame_blank,
    output logic [NDIG-1:0]     frame_err,
    output logic                overflow
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [6:0]        seg_s1, seg_s2;
    logic [NDIG-1:0]   an_s1, an_s2;

    logic              an_legal;
    logic [IW-1:0]     an_idx;

    scan_state_t       state;
    logic [IW-1:0]     cur_idx;
    logic [6:0]        cur_seg;
    logic [7:0]        cnt;

    logic              same_sample;
    logic              cap_fire;
    logic [3:0]        dec_val;
    logic              dec_blank;
    logic              dec_err;

    logic [4*NDIG-1:0] stg_val, stg_val_nxt;
    logic [NDIG-1:0]   stg_blank, stg_blank_nxt;
    logic [NDIG-1:0]   stg_err, stg_err_nxt;
    logic [NDIG-1:0]   mask, mask_nxt;
    logic              frame_done;

    // Two-flop synchronizer; reset to the idle bus (everything dark, no strobe).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1 <= SEG_BLANK;
            seg_s2 <= SEG_BLANK;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            an_s1  <= an_n;
            an_s2  <= an_s1;
        end
    end

    // Strobe legality (exactly one low) and index of the selected digit.
    always_comb begin
        an_legal = $onehot(~an_s2);
        an_idx   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_s2[i]) an_idx = IW'(i);
        end
    end

    assign same_sample = an_legal && (an_idx == cur_idx) && (seg_s2 == cur_seg);
    // Capture on the sample that brings the run of identical samples up to STABLE_CYC.
    assign cap_fire    = (state == SETTLE) && same_sample && (cnt == 8'(STABLE_CYC - 1));

    seg7_glyph_dec u_dec (
        .seg   (cur_seg),
        .val   (dec_val),
        .blank (dec_blank),
        .err   (dec_err)
    );

    // Scan FSM: track the current strobe/segment sample and count how long it has been stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_idx <= '0;
            cur_seg <= SEG_BLANK;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (an_legal) begin
                        state   <= SETTLE;
                        cur_idx <= an_idx;
                        cur_seg <= seg_s2;
                        cnt     <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (!an_legal) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!same_sample) begin
                        cur_idx <= an_idx;
                        cur_seg <= seg_s2;
                        cnt     <= 8'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cap_fire) state <= DONE;
                    end
                end
                DONE: begin
                    // Hold until the strobe or the segments under it move.
                    if (!an_legal) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!same_sample) begin
                        state   <= SETTLE;
                        cur_idx <= an_idx;
                        cur_seg <= seg_s2;
                        cnt     <= 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Staging write for the captured digit; the frame completes on the capture that fills the mask.
    always_comb begin
        stg_val_nxt   = stg_val;
        stg_blank_nxt = stg_blank;
        stg_err_nxt   = stg_err;
        mask_nxt      = mask;
        for (int i = 0; i < NDIG; i++) begin
            if (cap_fire && (cur_idx == IW'(i))) begin
                stg_val_nxt[4*i +: 4] = dec_val;
                stg_blank_nxt[i]      = dec_blank;
                stg_err_nxt[i]        = dec_err;
                mask_nxt[i]           = 1'b1;
            end
        end
        frame_done = cap_fire && (&mask_nxt);
    end

    // Staging registers and capture mask; the mask restarts once a frame completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_val   <= '0;
            stg_blank <= '0;
            stg_err   <= '0;
            mask      <= '0;
        end else begin
            stg_val   <= stg_val_nxt;
            stg_blank <= stg_blank_nxt;
            stg_err   <= stg_err_nxt;
            mask      <= frame_done ? '0 : mask_nxt;
        end
    end

    // Output frame register with valid/ready handshake and sticky overflow on a dropped frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_val   <= '0;
            frame_blank <= '0;
            frame_err   <= '0;
            overflow    <= 1'b0;
        end else if (frame_done) begin
            if (!frame_valid || frame_ready) begin
                frame_valid <= 1'b1;
                frame_val   <= stg_val_nxt;
                frame_blank <= stg_blank_nxt;
                frame_err   <= stg_err_nxt;
            end else begin
                overflow <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: expected frames are queued as scans are driven and popped on each handshake.
// Latency: inputs driven 1 time unit after rising edges, outputs sampled on falling edges.
// Backpressure: frame_ready is held low in one phase to force a held frame and an overflow.
module tb_seg7_scan_reader;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [6:0]        seg_n = 7'h7F;
    logic [NDIG-1:0]   an_n = '1;
    logic              frame_ready = 1'b1;
    logic              frame_valid;
    logic [4*NDIG-1:0] frame_val;
    logic [NDIG-1:0]   frame_blank;
    logic [NDIG-1:0]   frame_err;
    logic              overflow;

    seg7_scan_reader #(
        .NDIG       (NDIG),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_val   (frame_val),
        .frame_blank (frame_blank),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Active-low gfedcba glyphs for hex 0..F.
    logic [6:0] gl [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [15:0] val;
        logic [3:0]  blank;
        logic [3:0]  err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total  = 0;
    int   bad    = 0;
    int   n_xfer = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every accepted frame against the oldest expected one.
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            n_xfer++;
            if (sb.size() == 0) begin
                check("unexpected_frame_valid", 32'(frame_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("frame_val",   32'(frame_val),   32'(mon_e.val));
                check("frame_blank", 32'(frame_blank), 32'(mon_e.blank));
                check("frame_err",   32'(frame_err),   32'(mon_e.err));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int idx, input logic [6:0] s, input int n);
        an_n  = ~(4'(1) << idx);
        seg_n = s;
        step(n);
    endtask

    task automatic idle(input int n);
        an_n  = '1;
        seg_n = 7'h7F;
        step(n);
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input int n);
        show(0, s0, n);
        show(1, s1, n);
        show(2, s2, n);
        show(3, s3, n);
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] b, input logic [3:0] e);
        exp_t x;
        x.val   = v;
        x.blank = b;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) step(1);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},    32'(frame_valid), 32'd0);
        check({tag, "_val"},      32'(frame_val),   32'd0);
        check({tag, "_blank"},    32'(frame_blank), 32'd0);
        check({tag, "_err"},      32'(frame_err),   32'd0);
        check({tag, "_overflow"}, 32'(overflow),    32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2);

        // Plain scan 1,2,3,4
        push(16'h4321, 4'b0000, 4'b0000);
        scan4(gl[1], gl[2], gl[3], gl[4], 12);
        idle(4);
        drain("t1_drain");
        check("t1_valid_low", 32'(frame_valid), 32'd0);

        // Glitch on digit 2, then exactly STABLE_CYC clean samples of A
        push(16'h4A21, 4'b0000, 4'b0000);
        show(0, gl[1], 12);
        show(1, gl[2], 12);
        show(2, gl[10], 4);
        show(2, gl[8], 1);
        show(2, gl[10], STABLE_CYC);
        show(3, gl[4], 12);
        idle(4);
        drain("t2_drain");

        // Short dwells and a multi-low strobe never capture
        scan4(gl[5], gl[6], gl[7], gl[8], 6);
        scan4(gl[5], gl[6], gl[7], gl[8], STABLE_CYC - 1);
        an_n  = 4'b0011;
        seg_n = gl[3];
        step(20);
        idle(4);
        check("t4_valid_low", 32'(frame_valid), 32'd0);
        check("t4_no_xfer", 32'(n_xfer), 32'd2);

        // Blank and illegal patterns
        push(16'h0900, 4'b0010, 4'b1000);
        scan4(gl[0], 7'h7F, gl[9], 7'b0101010, 12);
        idle(4);
        drain("t3_drain");

        // Backpressure: first frame held, second dropped with overflow
        frame_ready = 1'b0;
        scan4(gl[5], gl[6], gl[7], gl[8], 12);
        idle(4);
        check("t5_valid_held", 32'(frame_valid), 32'd1);
        check("t5_val_first",  32'(frame_val),   32'h8765);
        check("t5_ovf_before", 32'(overflow),    32'd0);
        scan4(gl[9], gl[10], gl[11], gl[12], 12);
        idle(4);
        check("t5_valid_still", 32'(frame_valid), 32'd1);
        check("t5_val_kept",    32'(frame_val),   32'h8765);
        check("t5_overflow",    32'(overflow),    32'd1);
        push(16'h8765, 4'b0000, 4'b0000);
        frame_ready = 1'b1;
        step(1);
        check("t5_valid_drop", 32'(frame_valid), 32'd0);
        check("t5_sb_empty",   32'(sb.size()),   32'd0);

        // Reset mid-scan discards partial mask; next full scan alone makes a frame
        show(0, gl[13], 12);
        show(1, gl[14], 12);
        an_n  = '1;
        seg_n = 7'h7F;
        rst   = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        step(1);
        rst = 1'b0;
        step(2);
        push(16'h7698, 4'b0000, 4'b0000);
        show(2, gl[6], 12);
        show(3, gl[7], 12);
        show(0, gl[8], 12);
        show(1, gl[9], 12);
        idle(4);
        drain("t6_drain");
        check("t6_overflow", 32'(overflow), 32'd0);
        check("xfer_count", 32'(n_xfer), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
